// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, data width,
// and the clocks-per-bit derivation used to size the baud counter.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, restarts on request.
// tick is high on the edge that closes a bit period; no backpressure.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || !enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start + 8 data bits LSB-first + optional parity + stop bit(s).
// Accepts send one edge after request when idle; send while busy is dropped, not queued.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send,
    input  logic [DATA_W-1:0] transmit_data,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [15:0]       byte_count
);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_idx;
    logic              stop_idx;
    logic              parity_bit;
    logic              accept;
    logic              baud_en;
    logic              tick;

    assign accept  = (state == IDLE) && send;
    assign baud_en = (state != IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(accept),
        .enable (baud_en),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            byte_count <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        // Parity is taken from the captured byte, since shreg is consumed by shifting.
                        shreg      <= transmit_data;
                        parity_bit <= (^transmit_data) ^ (PARITY_ODD != 0);
                        bit_idx    <= '0;
                        busy       <= 1'b1;
                        tx         <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_W - 1)) begin
                            stop_idx <= 1'b0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            busy       <= 1'b0;
                            tx_done    <= 1'b1;
                            byte_count <= byte_count + 16'd1;
                            state      <= IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four configurations at 16 clocks per bit,
// expected line bits queued at send time and popped at each mid-bit sample.
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  transmit_data;
    logic [3:0]  send_v;
    logic [3:0]  tx_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [15:0] bc_v [4];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q [$];

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1)) u_8n1 (
        .clk(clk), .reset(reset), .send(send_v[0]), .transmit_data(transmit_data),
        .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .byte_count(bc_v[0]));
    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .reset(reset), .send(send_v[1]), .transmit_data(transmit_data),
        .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .byte_count(bc_v[1]));
    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .reset(reset), .send(send_v[2]), .transmit_data(transmit_data),
        .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .byte_count(bc_v[2]));
    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .send(send_v[3]), .transmit_data(transmit_data),
        .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .byte_count(bc_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Sends one byte on instance k and checks line bits, busy length, tx_done and count.
    // With inject set, extra send pulses land on edges 5, 80 and 160 (the busy-fall edge).
    task automatic run_frame(input int k, input logic [7:0] b, input int par_en,
                             input int par_odd, input int nstop, input bit inject,
                             input logic [15:0] exp_cnt);
        int nbits;
        int fall_c;
        int done_c;
        int done_n;
        int busy_seen;
        nbits = 1 + 8 + par_en + nstop;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (par_en != 0) exp_q.push_back((^b) ^ (par_odd != 0));
        for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
        fall_c = -1;
        done_c = -1;
        done_n = 0;
        busy_seen = 0;
        transmit_data = b;
        send_v[k] = 1'b1;
        step();
        send_v[k] = 1'b0;
        transmit_data = ~b;
        for (int c = 0; c <= nbits * 16 + 4; c++) begin
            if (c > 0) step();
            if (inject) send_v[k] = (c == 4 || c == 79 || c == 159);
            if (c % 16 == 8 && exp_q.size() > 0)
                chk($sformatf("k%0d %02h bit%0d", k, b, c / 16), 32'(tx_v[k]), 32'(exp_q.pop_front()));
            if (fall_c < 0 && !busy_v[k]) fall_c = c;
            if (done_v[k]) begin
                done_n++;
                done_c = c;
            end
        end
        send_v[k] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy_v[k] || !tx_v[k]) busy_seen++;
        end
        chk($sformatf("k%0d %02h busy_fall", k, b), fall_c, nbits * 16);
        chk($sformatf("k%0d %02h done_cycle", k, b), done_c, nbits * 16);
        chk($sformatf("k%0d %02h done_pulses", k, b), done_n, 1);
        chk($sformatf("k%0d %02h bits_left", k, b), exp_q.size(), 0);
        chk($sformatf("k%0d %02h idle_after", k, b), busy_seen, 0);
        chk($sformatf("k%0d %02h byte_count", k, b), 32'(bc_v[k]), 32'(exp_cnt));
    endtask

    initial begin
        int rise_n;
        int done_n;
        int rise_at [3];
        int done_at [2];
        logic prev_busy;

        reset = 1'b1;
        send_v = '0;
        transmit_data = '0;
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("k%0d rst tx", k), 32'(tx_v[k]), 32'd1);
            chk($sformatf("k%0d rst busy", k), 32'(busy_v[k]), 32'd0);
            chk($sformatf("k%0d rst done", k), 32'(done_v[k]), 32'd0);
            chk($sformatf("k%0d rst count", k), 32'(bc_v[k]), 32'd0);
        end
        reset = 1'b0;
        step();

        // T1: 8N1 frame, then a second byte to see the count advance.
        run_frame(0, 8'hA5, 0, 0, 1, 1'b0, 16'd1);
        run_frame(0, 8'h3E, 0, 0, 1, 1'b0, 16'd2);

        // T2: even and odd parity on 0x07.
        run_frame(1, 8'h07, 1, 0, 1, 1'b0, 16'd1);
        run_frame(2, 8'h07, 1, 1, 1, 1'b0, 16'd1);

        // T3: two stop bits.
        run_frame(3, 8'h00, 0, 0, 2, 1'b0, 16'd1);

        // T4: sends during the frame, including on the busy-fall edge, are dropped.
        do_reset();
        run_frame(0, 8'hC3, 0, 0, 1, 1'b1, 16'd1);

        // T5: send held high gives back-to-back frames with one idle cycle.
        do_reset();
        rise_n = 0;
        done_n = 0;
        rise_at = '{-1, -1, -1};
        done_at = '{-1, -1};
        transmit_data = 8'h5A;
        send_v[0] = 1'b1;
        prev_busy = busy_v[0];
        for (int c = 1; c <= 400; c++) begin
            step();
            if (busy_v[0] && !prev_busy) begin
                if (rise_n < 3) rise_at[rise_n] = c;
                rise_n++;
            end
            if (done_v[0]) begin
                if (done_n < 2) done_at[done_n] = c;
                done_n++;
            end
            if (c == 161) chk("T5 gap tx", 32'(tx_v[0]), 32'd1);
            if (c == 162) chk("T5 restart tx", 32'(tx_v[0]), 32'd0);
            if (c == 322) chk("T5 count@322", 32'(bc_v[0]), 32'd2);
            prev_busy = busy_v[0];
        end
        send_v[0] = 1'b0;
        chk("T5 rise0", rise_at[0], 1);
        chk("T5 rise1", rise_at[1], 162);
        chk("T5 rise2", rise_at[2], 323);
        chk("T5 done0", done_at[0], 161);
        chk("T5 done1", done_at[1], 322);
        for (int i = 0; i < 200 && busy_v[0]; i++) step();
        chk("T5 final busy", 32'(busy_v[0]), 32'd0);
        chk("T5 final count", 32'(bc_v[0]), 32'd3);

        // T6: asynchronous reset in the middle of a 0xFF frame.
        transmit_data = 8'hFF;
        send_v[0] = 1'b1;
        step();
        send_v[0] = 1'b0;
        repeat (69) step();
        chk("T6 busy before rst", 32'(busy_v[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("T6 async tx", 32'(tx_v[0]), 32'd1);
        chk("T6 async busy", 32'(busy_v[0]), 32'd0);
        chk("T6 async count", 32'(bc_v[0]), 32'd0);
        step();
        step();
        reset = 1'b0;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_v[0] || busy_v[0] || !tx_v[0]) done_n++;
        end
        chk("T6 quiet after rst", done_n, 0);
        run_frame(0, 8'h3C, 0, 0, 1, 1'b0, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
